// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and the iteration-counter sizing helper.
package alu_muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative hi/lo multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle over a shared WIDTH+1-bit adder/subtractor.
// Define ALU_MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[1]
// is ignored and MULT/DIV behave as MULTU/DIVU.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             divZero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] accHi_q;
  logic [WIDTH-1:0] accLo_q;
  logic [WIDTH-1:0] operand_q;
  logic [CW-1:0]    count_q;

  logic             isDiv;
  logic             divZero_d;
  logic [WIDTH-1:0] magA_d;
  logic [WIDTH-1:0] magB_d;
  logic [WIDTH-1:0] hiFin_d;
  logic [WIDTH-1:0] loFin_d;
  logic [WIDTH:0]   addX;
  logic [WIDTH:0]   addY;
  logic             addSub;
  logic [WIDTH:0]   addSum;

`ifdef ALU_MULDIV_SIGNED_EN
  logic             signedOp;
  logic             negA;
  logic             negB;
  logic             negRes_d;
  logic             negRem_d;
  logic             negRes_q;
  logic             negRem_q;
`endif

  // Decode the request and turn operands into magnitudes for the datapath.
  always_comb begin
    isDiv = 1'b0;
    case (op)
      OP_MULTU: isDiv = 1'b0;
      OP_DIVU:  isDiv = 1'b1;
      OP_MULT:  isDiv = 1'b0;
      OP_DIV:   isDiv = 1'b1;
      default:  isDiv = 1'b0;
    endcase
    divZero_d = isDiv && (b == '0);
`ifdef ALU_MULDIV_SIGNED_EN
    signedOp = (op == OP_MULT) || (op == OP_DIV);
    negA     = signedOp && a[WIDTH-1];
    negB     = signedOp && b[WIDTH-1];
    magA_d   = negA ? ({WIDTH{1'b0}} - a) : a;
    magB_d   = negB ? ({WIDTH{1'b0}} - b) : b;
    negRes_d = (negA ^ negB) && !divZero_d;
    negRem_d = negA && isDiv && !divZero_d;
`else
    magA_d   = a;
    magB_d   = b;
`endif
  end

  // One adder serves both loops: add multiplicand or trial-subtract divisor.
  always_comb begin
    addX   = {1'b0, accHi_q};
    addY   = accLo_q[0] ? {1'b0, operand_q} : '0;
    addSub = 1'b0;
    if (state_q == ST_DIV) begin
      addX   = {accHi_q, accLo_q[WIDTH-1]};
      addY   = {1'b0, operand_q};
      addSub = 1'b1;
    end
    addSum = addX + (addY ^ {(WIDTH+1){addSub}}) + {{WIDTH{1'b0}}, addSub};
  end

  // Final hi/lo values, with the sign restored for signed operations.
  always_comb begin
    hiFin_d = accHi_q;
    loFin_d = accLo_q;
`ifdef ALU_MULDIV_SIGNED_EN
    if (state_q == ST_MUL) begin
      if (negRes_q) {hiFin_d, loFin_d} = {(2*WIDTH){1'b0}} - {accHi_q, accLo_q};
    end else begin
      if (negRes_q) loFin_d = {WIDTH{1'b0}} - accLo_q;
      if (negRem_q) hiFin_d = {WIDTH{1'b0}} - accHi_q;
    end
`endif
  end

  // Controller and datapath registers, with hi/lo written only at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      operand_q <= '0;
      count_q   <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_hi) hi_q <= wr_data;
          if (wr_lo) lo_q <= wr_data;
          if (start) begin
            state_q   <= isDiv ? ST_DIV : ST_MUL;
            busy_q    <= 1'b1;
            count_q   <= '0;
            divZero_q <= divZero_d;
`ifdef ALU_MULDIV_SIGNED_EN
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
`endif
            if (divZero_d) begin
              accHi_q   <= a;
              accLo_q   <= '1;
              operand_q <= '0;
            end else if (isDiv) begin
              accHi_q   <= '0;
              accLo_q   <= magA_d;
              operand_q <= magB_d;
            end else begin
              accHi_q   <= '0;
              accLo_q   <= magB_d;
              operand_q <= magA_d;
            end
          end
        end
        ST_MUL: begin
          if (count_q == LAST) begin
            hi_q    <= hiFin_d;
            lo_q    <= loFin_d;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            accHi_q <= addSum[WIDTH:1];
            accLo_q <= {addSum[0], accLo_q[WIDTH-1:1]};
            count_q <= count_q + CW'(1);
          end
        end
        ST_DIV: begin
          if (divZero_q || (count_q == LAST)) begin
            hi_q    <= hiFin_d;
            lo_q    <= loFin_d;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            if (!addSum[WIDTH]) begin
              accHi_q <= addSum[WIDTH-1:0];
              accLo_q <= {accLo_q[WIDTH-2:0], 1'b1};
            end else begin
              accHi_q <= {accHi_q[WIDTH-2:0], accLo_q[WIDTH-1]};
              accLo_q <= {accLo_q[WIDTH-2:0], 1'b0};
            end
            count_q <= count_q + CW'(1);
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = divZero_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32): stimulus pushes expected
// results, an independent monitor pops and compares on every done pulse.
// Signed expectations apply when ALU_MULDIV_SIGNED_EN is defined.
module tb_alu_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   opIn;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t expQ[$];
  exp_t monE;
  int   cycleCnt = 0;
  int   tests    = 0;
  int   errors   = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(opIn),
    .a(aIn),
    .b(bIn),
    .wr_hi(wr_hi),
    .wr_lo(wr_lo),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time done against the accept edge.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        tests++;
        errors++;
        $display("[TB] FAIL unexpectedDone: done=1 at cycle %0d, expected 0", cycleCnt);
      end else begin
        monE = expQ.pop_front();
        checkOutput("doneCycle", 64'(cycleCnt), 64'(monE.cyc));
        checkOutput("hi", 64'(hi), 64'(monE.hi));
        checkOutput("lo", 64'(lo), 64'(monE.lo));
        checkOutput("divByZero", 64'(div_by_zero), 64'(monE.dbz));
      end
    end
  end

  // Issue one operation from a negedge while idle; returns one cycle after accept.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic [W-1:0] expHi,
                               input logic [W-1:0] expLo, input logic expDbz,
                               input int lat);
    opIn  = op;
    aIn   = av;
    bIn   = bv;
    start = 1'b1;
    expQ.push_back('{hi: expHi, lo: expLo, dbz: expDbz, cyc: cycleCnt + 1 + lat});
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    opIn  = 2'b11;
    aIn   = 32'hDEADBEEF;
    bIn   = 32'h0BADF00D;
  endtask

  task automatic waitDone();
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      errors++;
      $display("[TB] FAIL waitDone: %0d results pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Global time bound so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    opIn    = 2'b00;
    aIn     = '0;
    bIn     = '0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetDbz", 64'(div_by_zero), 64'd0);
    checkOutput("resetHi", 64'(hi), 64'd0);
    checkOutput("resetLo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT);
    checkOutput("busyAfterAccept", 64'(busy), 64'd1);
    waitDone();

    applyStimulus(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT);
    repeat (5) @(negedge clk);
    start = 1'b1;
    opIn  = 2'b00;
    aIn   = 32'd5;
    bIn   = 32'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("busyAfterIgnoredStart", 64'(busy), 64'd0);

    applyStimulus(2'b01, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1);
    waitDone();
    repeat (2) @(negedge clk);
    checkOutput("dbzSticky", 64'(div_by_zero), 64'd1);
    applyStimulus(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, LAT);
    waitDone();

`ifdef ALU_MULDIV_SIGNED_EN
    applyStimulus(2'b10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, LAT);
    waitDone();
`else
    applyStimulus(2'b10, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT);
    waitDone();
`endif

    applyStimulus(2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, LAT);
    waitDone();
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, LAT);
    waitDone();

    // Reset lands on the tenth edge after accept of a multiply.
    opIn  = 2'b00;
    aIn   = 32'h12345678;
    bIn   = 32'h9ABCDEF0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midOpHi", 64'(hi), 64'd0);
    checkOutput("midOpLo", 64'(lo), 64'hFFFFFFFF);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    checkOutput("abortHi", 64'(hi), 64'd0);
    checkOutput("abortLo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("abortStaysIdle", 64'(busy), 64'd0);

    wr_lo   = 1'b1;
    wr_data = 32'h000000A5;
    @(negedge clk);
    wr_lo = 1'b0;
    checkOutput("idleWriteLo", 64'(lo), 64'h000000A5);
    checkOutput("idleWriteHiUntouched", 64'(hi), 64'd0);

    applyStimulus(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, LAT);
    wr_hi   = 1'b1;
    wr_data = 32'h0000DEAD;
    @(negedge clk);
    wr_hi = 1'b0;
    @(negedge clk);
    checkOutput("busyWriteHiIgnored", 64'(hi), 64'd0);
    checkOutput("busyLoHeld", 64'(lo), 64'h000000A5);
    waitDone();

    wr_lo   = 1'b1;
    wr_data = 32'h00000055;
    applyStimulus(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, LAT);
    checkOutput("sameCycleWriteLo", 64'(lo), 64'h00000055);
    waitDone();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (>=4).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request new operation; accepted only when busy=0.
REQ-005 Port: op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 Port: a  input  WIDTH  multiplicand / dividend.
REQ-007 Port: b  input  WIDTH  multiplier / divisor.
REQ-008 Port: wr_hi  input  1  load hi from wr_data (MTHI).
REQ-009 Port: wr_lo  input  1  load lo from wr_data (MTLO).
REQ-010 Port: wr_data  input  WIDTH  MTHI/MTLO data.
REQ-011 Port: busy  output  1  operation in progress.
REQ-012 Port: done  output  1  one-cycle pulse, hi/lo valid.
REQ-013 Port: div_by_zero  output  1  sticky flag for last operation, b==0 on DIVU/DIV.
REQ-014 Port: hi  output  WIDTH  product upper half / remainder.
REQ-015 Port: lo  output  WIDTH  product lower half / quotient.

Function
REQ-016 FSM states IDLE, MUL, DIV, FIN; IDLE->MUL/DIV on accepted start, MUL/DIV->FIN after WIDTH iterations, FIN->IDLE unconditionally.
REQ-017 Accept = start & ~busy; a, b, op captured at accept; later input changes ignored.
REQ-018 busy=1 from cycle after accept through FIN inclusive; done=1 only in FIN.
REQ-019 Latency: done asserted exactly WIDTH+1 cycles after accept edge; hi/lo update on same edge done rises.
REQ-020 Multiply: shift-add, one multiplier bit per cycle; {hi,lo} = full 2*WIDTH product.
REQ-021 Divide: restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
REQ-022 Divide by zero: no iteration; next state FIN (done 1 cycle after accept); hi = a, lo = all ones, div_by_zero=1.
REQ-023 div_by_zero cleared on every accepted start with b!=0 or non-divide op.
REQ-024 start while busy: ignored, no queueing, no error.
REQ-025 wr_hi/wr_lo while busy: ignored; while idle: applied next edge.
REQ-026 wr_hi/wr_lo and accepted start same cycle: write applied, then overwritten at done.
REQ-027 hi/lo hold value between operations; never change mid-operation.

Reset
REQ-028 reset synchronous, active-high, priority over all inputs.
REQ-029 Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0, internal counters 0.
REQ-030 reset mid-operation aborts; no done pulse; hi/lo return 0.

Configuration
REQ-031 Macro ALU_MULDIV_SIGNED_EN defined: MULT/DIV two's-complement; operands converted to magnitude at accept, sign fixed at FIN.
REQ-032 Signed rules: product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign; MIN/-1 gives lo=MIN, hi=0.
REQ-033 Macro undefined: op[1] ignored, MULT/DIV behave as MULTU/DIVU; no sign logic synthesised.

Structure
REQ-034 Package alu_muldiv_pkg: op encodings, FSM state typedef, iteration-counter width function (clog2(WIDTH+1)).
REQ-035 Single module; no sub-module; shared WIDTH+1-bit adder/subtractor reused by MUL and DIV.

Verification (WIDTH=32)
REQ-036 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at accept+33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 DIVU a=100 b=7 -> lo=14, hi=2, div_by_zero=0; start pulsed while busy ignored, single done.
REQ-038 DIVU a=0x1234 b=0 -> done at accept+1, hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; next MULTU clears flag.
REQ-039 SIGNED_EN: DIV a=-7 b=2 -> lo=-3 (0xFFFFFFFD), hi=-1; MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; without macro MULT a=-3 b=5 -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-040 reset at accept+10 of MULTU -> busy 0 next cycle, no done, hi=lo=0; wr_lo=1 wr_data=0xA5 idle -> lo=0xA5.
